sysid_check_master: RTL and testbench

//  Avalon-MM read initiator for the system-ID control slave (1-bit word address:
//  0 = ID word, 1 = build-timestamp word). On start, reads both words and

---
 rtl/sysid_check_master.sv | 84 ++++++++
 tb/tb_sysid_check_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master: reads sysid ID and timestamp words over Avalon-MM and flags mismatch or timeout
// Ports: clock, reset (sync, active-high); start pulse; avm_* single-outstanding read master;
//        busy, done pulse, sticky id_ok/ts_ok/timed_out, captured id_value/ts_value.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1489607473,
    parameter logic [15:0] TIMEOUT     = 16'd1023,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timed_out,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {IDLE, CMD_ID, RSP_ID, CMD_TS, RSP_TS, FIN} state_t;
    state_t state, nxt;
    logic [15:0] cnt;
    logic auto_pend, cmd, rsp, ts, acc, got, expire;
    always_comb begin
        cmd = state == CMD_ID || state == CMD_TS;
        rsp = state == RSP_ID || state == RSP_TS;
        ts = state == CMD_TS || state == RSP_TS;
        acc = cmd && !avm_waitrequest;
        // data in the accept cycle counts; data beats a coincident timeout
        got = (rsp || acc) && avm_readdatavalid;
        expire = (cmd || rsp) && !got && cnt == TIMEOUT;
        nxt = state == IDLE ? ((start || auto_pend) ? CMD_ID : IDLE) :
              state == FIN  ? IDLE :
              got           ? (ts ? FIN : CMD_TS) :
              expire        ? FIN :
              acc           ? (ts ? RSP_TS : RSP_ID) : state;
    end
    assign busy = state != IDLE && state != FIN;
    assign done = state == FIN;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 16'd0;
            auto_pend <= AUTO_START;
            avm_read <= 1'b0;
            avm_address <= 1'b0;
            id_ok <= 1'b0;
            ts_ok <= 1'b0;
            timed_out <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            state <= nxt;
            auto_pend <= auto_pend && state != IDLE;
            avm_read <= nxt == CMD_ID || nxt == CMD_TS;
            avm_address <= nxt == CMD_TS || nxt == RSP_TS;
            cnt <= (nxt != state && (nxt == CMD_ID || nxt == CMD_TS)) ? 16'd0 :
                   (cmd || rsp) ? cnt + 16'd1 : cnt;
            if (state == IDLE && nxt == CMD_ID) begin
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
                timed_out <= 1'b0;
                id_value <= 32'd0;
                ts_value <= 32'd0;
            end
            if (got && !ts) begin
                id_value <= avm_readdata;
                id_ok <= avm_readdata == EXPECTED_ID;
            end
            if (got && ts) begin
                ts_value <= avm_readdata;
                ts_ok <= avm_readdata == EXPECTED_TS;
            end
            if (expire)
                timed_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: randomized slave stimulus checked per cycle against a timeline model
module tb_sysid_check_master;
    localparam logic [15:0] TO = 16'd8;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1489607473;
    localparam int NEVER = 1000;
    typedef struct packed {
        logic busy, done, rd, addr, id_ok, ts_ok, to;
        logic [31:0] idv, tsv;
    } exp_t;
    logic clock = 0, reset = 1, start = 0;
    logic avm_address, avm_read, busy, done, id_ok, ts_ok, timed_out;
    logic avm_waitrequest = 0, avm_readdatavalid = 0;
    logic [31:0] avm_readdata = 0, id_value, ts_value;
    int checks = 0, fails = 0;
    bit chk_en = 0;
    int sw[2], sl[2];
    logic [31:0] sd[2];
    exp_t exp_q[$], tl[$];
    exp_t last = '0;
    int wcnt = 0, lcnt = 0;
    bit pend = 0;
    logic [31:0] pdata = 0;
    always #5 clock = ~clock;
    sysid_check_master #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
        .timed_out(timed_out), .id_value(id_value), .ts_value(ts_value)
    );
    // Slave: sw waitstates per read, data sl cycles after acceptance (0 = same cycle, NEVER = none)
    initial forever begin
        @(negedge clock);
        avm_waitrequest = 0;
        avm_readdatavalid = 0;
        if (reset) begin
            pend = 0;
            wcnt = 0;
        end else if (pend) begin
            lcnt--;
            if (lcnt == 0) begin
                pend = 0;
                avm_readdatavalid = 1;
                avm_readdata = pdata;
            end
        end else if (avm_read) begin
            if (wcnt < sw[avm_address]) begin
                wcnt++;
                avm_waitrequest = 1;
                if ($urandom_range(3) == 0) begin
                    avm_readdatavalid = 1;
                    avm_readdata = $urandom;
                end
            end else begin
                wcnt = 0;
                if (sl[avm_address] == 0) begin
                    avm_readdatavalid = 1;
                    avm_readdata = sd[avm_address];
                end else if (sl[avm_address] < NEVER) begin
                    pend = 1;
                    lcnt = sl[avm_address];
                    pdata = sd[avm_address];
                end
            end
        end else
            wcnt = 0;
    end
    // Per-cycle expectation from first CMD cycle to FIN: each read phase lasts
    // min(wait+latency, TO)+1 cycles; read is high until acceptance.
    function automatic void build(int w0, int l0, int w1, int l1, logic [31:0] d0, logic [31:0] d1);
        int w[2], l[2], lat, fin;
        logic [31:0] d[2];
        exp_t e;
        w = '{w0, w1};
        l = '{l0, l1};
        d = '{d0, d1};
        tl.delete();
        e = '0;
        e.busy = 1;
        for (int p = 0; p < 2 && !e.to; p++) begin
            lat = l[p] >= NEVER ? NEVER : w[p] + l[p];
            fin = lat < int'(TO) ? lat : int'(TO);
            for (int k = 0; k <= fin; k++) begin
                e.rd = k <= w[p];
                e.addr = p[0];
                tl.push_back(e);
            end
            if (lat > int'(TO))
                e.to = 1;
            else if (p == 0) begin
                e.idv = d[0];
                e.id_ok = d[0] == EID;
            end else begin
                e.tsv = d[1];
                e.ts_ok = d[1] == ETS;
            end
        end
        e.busy = 0;
        e.done = 1;
        e.rd = 0;
        e.addr = 0;
        tl.push_back(e);
    endfunction
    function automatic int count_rd();
        int n = 0;
        foreach (tl[i]) n += int'(tl[i].rd);
        return n;
    endfunction
    function automatic int count_busy();
        int n = 0;
        foreach (tl[i]) n += int'(tl[i].busy);
        return n;
    endfunction
    always @(negedge clock) if (chk_en) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last = e;
        end else begin
            e = last;
            e.busy = 0;
            e.done = 0;
            e.rd = 0;
        end
        checks++;
        if ({busy, done, avm_read, id_ok, ts_ok, timed_out, id_value, ts_value} !==
            {e.busy, e.done, e.rd, e.id_ok, e.ts_ok, e.to, e.idv, e.tsv} || (e.rd && avm_address !== e.addr)) begin
            fails++;
            $display("FAIL cycle @%0t busy,done,rd,addr,id_ok,ts_ok,to,id,ts got %b%b%b%b %b%b%b %h %h want %b%b%b%b %b%b%b %h %h",
                     $time, busy, done, avm_read, avm_address, id_ok, ts_ok, timed_out, id_value, ts_value,
                     e.busy, e.done, e.rd, e.addr, e.id_ok, e.ts_ok, e.to, e.idv, e.tsv);
        end
    end
    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask
    task automatic set_sc(int w0, int l0, int w1, int l1, logic [31:0] d0, logic [31:0] d1);
        sw = '{w0, w1};
        sl = '{l0, l1};
        sd = '{d0, d1};
        build(w0, l0, w1, l1, d0, d1);
    endtask
    task automatic play(int spur, int cut);
        foreach (tl[i]) exp_q.push_back(tl[i]);
        for (int c = 0; c < tl.size() && c != cut; c++) begin
            start = c == spur;
            @(posedge clock); #1;
        end
        start = 0;
    endtask
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask
    task automatic run_check(int w0, int l0, int w1, int l1, logic [31:0] d0, logic [31:0] d1, int spur, int cut, int gap);
        set_sc(w0, l0, w1, l1, d0, d1);
        start = 1;
        @(posedge clock); #1;
        play(spur, cut);
        idle(gap);
    endtask
    task automatic reset_auto(int w0, int l0, int w1, int l1, logic [31:0] d0, logic [31:0] d1, int spur);
        exp_t e;
        reset = 1;
        if (exp_q.size() > 1) begin
            e = exp_q[0];
            exp_q.delete();
            exp_q.push_back(e);
        end
        e = '0;
        exp_q.push_back(e);
        @(posedge clock); #1;
        reset = 0;
        set_sc(w0, l0, w1, l1, d0, d1);
        @(posedge clock); #1;
        play(spur, -1);
        idle(20);
    endtask
    function automatic int rand_w();
        int r = $urandom_range(9);
        return r < 8 ? r % 4 : r + 1;
    endfunction
    function automatic int rand_l();
        int r = $urandom_range(11);
        return r < 8 ? r % 6 : r < 10 ? NEVER : 10 + $urandom_range(5);
    endfunction
    function automatic logic [31:0] rand_d(logic [31:0] good);
        int r = $urandom_range(3);
        return r < 2 ? good : r == 2 ? good ^ (32'd1 << $urandom_range(31)) : 32'($urandom);
    endfunction
    initial begin
        @(posedge clock); #1;
        chk_en = 1;
        reset_auto(0, 0, 0, 0, EID, ETS, -1);
        chk("t1 model length", tl.size(), 3);
        chk("t1 model read cycles", count_rd(), 2);
        chk("t1 id_ok", 32'(id_ok), 1);
        chk("t1 ts_ok", 32'(ts_ok), 1);
        chk("t1 timed_out", 32'(timed_out), 0);
        run_check(0, 1, 1, 0, EID, 32'h58C2_0000, 2, -1, 20);
        chk("t2 ts_value", ts_value, 32'h58C2_0000);
        chk("t2 ts_ok", 32'(ts_ok), 0);
        chk("t2 id_ok", 32'(id_ok), 1);
        run_check(5, 0, 5, 0, EID, ETS, 7, -1, 20);
        chk("t3 model busy cycles", count_busy(), 12);
        chk("t3 ts_ok", 32'(ts_ok), 1);
        run_check(0, NEVER, 0, 0, EID, ETS, -1, -1, 20);
        chk("t4 model length", tl.size(), 10);
        chk("t4 model timeout in FIN", 32'({tl[9].done, tl[9].to}), 3);
        chk("t4 timed_out", 32'(timed_out), 1);
        chk("t4 id_ok", 32'(id_ok), 0);
        chk("t4 ts_ok", 32'(ts_ok), 0);
        run_check(0, 0, 0, NEVER, EID, ETS, -1, 5, 0);
        reset_auto(1, 2, 2, 1, EID, ETS, 3);
        chk("t5 id_ok", 32'(id_ok), 1);
        chk("t5 ts_ok", 32'(ts_ok), 1);
        for (int i = 0; i < 60; i++)
            run_check(rand_w(), rand_l(), rand_w(), rand_l(), rand_d(EID), rand_d(ETS),
                      $urandom_range(1) ? int'($urandom_range(20)) : -1, -1, 20);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
